trace_vector_packer: RTL and testbench
======================================

Name: trace_vector_packer

Overview:
- Upstream transmitter for the input buffer's enqueue interface.
- Accepts a narrow element stream, one DATA_WIDTH element per handshake, from the traced accelerator tap.
- Packs N elements into a vector and drives enqueue/vector/eof into the input buffer, with frame boundaries taken from a configured frame length or an explicit last flag.
- Reconfigured over the shared configId/configData bus while tracing is low.

Parameters:
- N, 8, elements per vector; must match the input buffer N.
- DATA_WIDTH, 32, bits per element.
- INITIAL_FRAME_LEN, 4, vectors per frame after reset; 0 means unbounded.
- PERSONAL_CONFIG_ID, 0, configId value that selects this block.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tracing  in  1  1 = trace mode, 0 = config mode.
- configId  in  8  config target select.
- configData  in  8  config payload, giving the frame length in vectors.
- elem_valid  in  1  source has an element.
- elem_data  in  DATA_WIDTH  element value.
- elem_last  in  1  element is the last of its frame.
- elem_ready  out  1  block accepts an element this cycle.
- enqueue  out  1  one-cycle pulse; vector_out/eof_out valid.
- eof_out  out  1  vector closes a frame; qualified by enqueue.
- vector_out  out  N x DATA_WIDTH  packed vector; lane 0 = first element accepted.
- dropped_count  out  16  saturating count of partial vectors discarded.

Behaviour:
- Reset (rst_n=0, async):
  - Outputs: enqueue=0, eof_out=0, vector_out all 0, dropped_count=0.
  - Internal: lane index=0, staging=0, frame vector count=0, frame_len=INITIAL_FRAME_LEN.
  - Reset asserted mid-frame discards all staged data with no enqueue.
- Accept rules:
  - elem_ready = tracing, combinational; there is no backpressure.
  - Accept = elem_valid & elem_ready. An accepted element is written into staging lane [lane index], and lane index increments.
- Emit rules:
  - Emit happens on an accept that either fills lane N-1 or carries elem_last=1.
  - On the next edge: vector_out = staging merged with the new element, unfilled lanes = 0; enqueue=1 for exactly one cycle.
  - On that same edge, staging and lane index clear. An accept in the very next cycle lands in lane 0, so there is no bubble; sustained throughput is one vector per N cycles.
  - Latency: completing accept at edge k gives enqueue high during cycle k+1.
- Framing:
  - The frame vector count increments per emit.
  - eof_out=1 on an emit when elem_last=1, or when frame_len!=0 and count==frame_len-1. After such an emit the count resets to 0.
  - frame_len=0 means only elem_last ends a frame.
  - elem_last on a full lane N-1 produces a single emit with eof; there is no extra empty vector.
  - eof_out=0 whenever enqueue=0.
- Config mode (tracing=0):
  - elem_ready=0 and enqueue=0.
  - If configId==PERSONAL_CONFIG_ID, then frame_len <= configData, sampled every such cycle.
  - Config writes while tracing=1 are ignored.
- Tracing falling edge: any partial vector (lane index>0) is discarded, and dropped_count increments by 1, saturating at 16'hFFFF. Lane index and frame count clear. Nothing is flushed, because the input buffer ignores enqueue while not tracing.
- Simultaneity: an accept and a tracing fall cannot coincide, because elem_ready already falls with tracing. If frame_len changes mid-frame, the new value applies to the next emit comparison.
- Width: lane index and frame count are $clog2(N) and 8 bits; compares use zero-extended operands.

Test Plan:
- Reset, then tracing=1, N=8, frame_len=4, 32 back-to-back elements 1..32 -> 4 enqueue pulses at cycles 8, 16, 24, 32 after the first accept. Vector 0 lanes = 1..8; eof_out only on the 4th pulse.
- 3 elements (A, B, C) with elem_last on C -> one enqueue, vector = {A, B, C, 0, 0, 0, 0, 0}, eof_out=1, next frame count starts at 0.
- tracing=0, configId=PERSONAL_CONFIG_ID, configData=2, then tracing=1 and 32 elements -> eof on every 2nd vector. A configId mismatch leaves frame_len unchanged.
- 5 elements then tracing drops -> no enqueue, dropped_count=1. A new 8-element stream fills lanes 0..7 cleanly.
- frame_len=0, 24 elements with elem_last on the 24th -> 3 enqueues, eof only on the 3rd. elem_last on element 8 gives exactly one pulse.
- Assert rst_n low mid-vector (lane index 6), release -> enqueue stays 0, frame_len=INITIAL_FRAME_LEN, first 8 new elements form lanes 0..7.

Source files
------------

// File: rtl/trace_vector_packer.sv
// -----------------------------------------------------------------------------
// trace_vector_packer
//
// Packs a stream of DATA_WIDTH-bit elements from the traced accelerator tap
// into N-lane vectors. Each vector goes to the input buffer's enqueue
// interface. A frame ends when the configured frame length in vectors is
// reached, or when the source flags its last element. The frame length is
// programmed over the shared configId/configData bus while tracing is low.
//
// Parameters
//   N                  elements per vector; must match the input buffer.
//   DATA_WIDTH         bits per element.
//   INITIAL_FRAME_LEN  frame length in vectors after reset; 0 = unbounded.
//   PERSONAL_CONFIG_ID configId value that addresses this block.
//
// Ports
//   clk            clock; all logic runs on the rising edge.
//   rst_n          asynchronous active-low reset.
//   tracing        1 = trace mode, 0 = config mode.
//   configId       config target select.
//   configData     config payload: the frame length in vectors.
//   elem_valid     the source has an element.
//   elem_data      element value.
//   elem_last      the element is the last of its frame.
//   elem_ready     an element is accepted this cycle (equal to tracing).
//   enqueue        one-cycle pulse; vector_out/eof_out are valid.
//   eof_out        the vector closes a frame; qualified by enqueue.
//   vector_out     packed vector; lane 0 holds the first element accepted.
//   dropped_count  saturating count of partial vectors discarded.
// -----------------------------------------------------------------------------
module trace_vector_packer #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int INITIAL_FRAME_LEN  = 4,
    parameter int PERSONAL_CONFIG_ID = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tracing,
    input  logic [7:0]                      configId,
    input  logic [7:0]                      configData,
    input  logic                            elem_valid,
    input  logic [DATA_WIDTH-1:0]           elem_data,
    input  logic                            elem_last,
    output logic                            elem_ready,
    output logic                            enqueue,
    output logic                            eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
    output logic [15:0]                     dropped_count
);

    // Lane index width. The guard keeps the index legal if N is ever 1.
    localparam int                LANE_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);
    localparam logic [7:0]        CFG_ID    = 8'(PERSONAL_CONFIG_ID);
    localparam logic [7:0]        FLEN_INIT = 8'(INITIAL_FRAME_LEN);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N-1:0][DATA_WIDTH-1:0] staging;     // lanes filled so far
    logic [LANE_W-1:0]            lane_idx;    // next lane to fill
    logic [7:0]                   frame_cnt;   // vectors emitted in this frame
    logic [7:0]                   frame_len;   // vectors per frame; 0 = unbounded
    logic                         tracing_q;   // tracing from the previous cycle

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic                         accept;
    logic                         lane_full;
    logic                         emit;
    logic                         frame_end;
    logic                         tracing_fall;
    logic                         config_write;
    logic [N-1:0][DATA_WIDTH-1:0] merged;

    // There is no backpressure: the block takes an element on every
    // trace-mode cycle.
    assign elem_ready   = tracing;
    assign accept       = elem_valid & elem_ready;
    assign lane_full    = (lane_idx == LAST_LANE);
    assign emit         = accept & (lane_full | elem_last);
    assign tracing_fall = tracing_q & ~tracing;
    assign config_write = ~tracing & (configId == CFG_ID);

    // The frame closes on an explicit last, or when this emit is the
    // frame_len-th vector. The compare uses widened operands so that
    // frame_len = 0 never matches through an underflowed frame_len - 1.
    assign frame_end = elem_last |
                       ((frame_len != 8'd0) &&
                        (({1'b0, frame_cnt} + 9'd1) == {1'b0, frame_len}));

    // The staged lanes with the incoming element dropped into its lane.
    // Lanes above lane_idx are still zero, so the unfilled lanes of a
    // short vector leave as zero.
    // NOTE: always_comb assigns a full default before any conditional
    // write, so no path leaves merged unassigned and no latch is inferred.
    always_comb begin
        merged           = staging;
        merged[lane_idx] = elem_data;
    end

    // -------------------------------------------------------------------------
    // Staging lanes and lane index
    // -------------------------------------------------------------------------
    // NOTE: staging gets a reset even though it is wide, because a reset
    // part-way through a vector must not leak old lanes into the next short
    // vector. Its zero lanes are visible on vector_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging  <= '0;
            lane_idx <= '0;
        end else if (tracing_fall || emit) begin
            // A dropped partial vector and a completed vector both restart
            // at lane 0. This lets an accept in the very next cycle land in
            // lane 0 with no bubble.
            staging  <= '0;
            lane_idx <= '0;
        end else if (accept) begin
            // NOTE: sequential state is updated with non-blocking
            // assignments only, so every register here sees the pre-edge
            // values of the others, whatever the statement order.
            staging[lane_idx] <= elem_data;
            lane_idx          <= lane_idx + LANE_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Frame vector count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tracing_fall) begin
            frame_cnt <= '0;
        end else if (emit) begin
            frame_cnt <= frame_end ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame length register
    // -------------------------------------------------------------------------
    // The register is written on every config-mode cycle that addresses this
    // block. A new value takes effect at the next emit comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_len <= FLEN_INIT;
        end else if (config_write) begin
            frame_len <= configData;
        end
    end

    // -------------------------------------------------------------------------
    // Tracing edge detect and drop counter
    // -------------------------------------------------------------------------
    // tracing_q resets to 0, so a reset released with tracing high does not
    // count as a fall. The partial vector is never flushed on a fall,
    // because the input buffer ignores enqueue once tracing is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracing_q     <= 1'b0;
            dropped_count <= '0;
        end else begin
            tracing_q <= tracing;
            if (tracing_fall && (lane_idx != '0) && (dropped_count != 16'hFFFF)) begin
                dropped_count <= dropped_count + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered enqueue interface
    // -------------------------------------------------------------------------
    // A completing accept at edge k gives enqueue high during cycle k+1.
    // vector_out holds its last value between pulses. eof_out is tied to
    // the pulse, so it is never high without enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enqueue    <= 1'b0;
            eof_out    <= 1'b0;
            vector_out <= '0;
        end else begin
            enqueue <= emit;
            eof_out <= emit & frame_end;
            if (emit) begin
                vector_out <= merged;
            end
        end
    end

endmodule

// File: tb/tb_trace_vector_packer.sv
// -----------------------------------------------------------------------------
// tb_trace_vector_packer
//
// Directed bench for trace_vector_packer (N=8, DATA_WIDTH=32, initial frame
// length 4, config id 0). Stimulus is driven 1 time unit after the rising
// edge, and outputs are sampled at that same point after the next edge. A
// small reference model tracks the lane index, frame count, frame length and
// drop count. It uses these to predict each enqueue pulse, vector and eof.
// -----------------------------------------------------------------------------
module tb_trace_vector_packer;

    localparam int         N   = 8;
    localparam int         DW  = 32;
    localparam logic [7:0] PID = 8'd0;

    logic                    clk;
    logic                    rst_n;
    logic                    tracing;
    logic [7:0]              configId;
    logic [7:0]              configData;
    logic                    elem_valid;
    logic [DW-1:0]           elem_data;
    logic                    elem_last;
    logic                    elem_ready;
    logic                    enqueue;
    logic                    eof_out;
    logic [N-1:0][DW-1:0]    vector_out;
    logic [15:0]             dropped_count;

    trace_vector_packer #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .INITIAL_FRAME_LEN  (4),
        .PERSONAL_CONFIG_ID (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tracing       (tracing),
        .configId      (configId),
        .configData    (configData),
        .elem_valid    (elem_valid),
        .elem_data     (elem_data),
        .elem_last     (elem_last),
        .elem_ready    (elem_ready),
        .enqueue       (enqueue),
        .eof_out       (eof_out),
        .vector_out    (vector_out),
        .dropped_count (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                   m_lane = 0;
    int                   m_fcnt = 0;
    int                   m_flen = 4;
    int                   m_drop = 0;
    logic [N-1:0][DW-1:0] m_vec  = '0;

    task automatic check(input string tag, input logic [N*DW-1:0] got,
                         input logic [N*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one element for one cycle, then check the resulting pulse.
    task automatic send(input logic [DW-1:0] d, input logic last);
        logic exp_emit;
        logic exp_eof;
        elem_valid     = 1'b1;
        elem_data      = d;
        elem_last      = last;
        m_vec[m_lane]  = d;
        exp_emit       = last || (m_lane == N - 1);
        exp_eof        = exp_emit && (last || (m_flen != 0 && m_fcnt == m_flen - 1));
        @(posedge clk); #1;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        check("enqueue", enqueue, exp_emit);
        check("eof_out", eof_out, exp_eof);
        if (exp_emit) begin
            check("vector_out", vector_out, m_vec);
            m_vec  = '0;
            m_lane = 0;
            m_fcnt = exp_eof ? 0 : m_fcnt + 1;
        end else begin
            m_lane++;
        end
    endtask

    // Back-to-back elements first..first+count-1; last_at (1-based) flags
    // elem_last on that element, 0 = never.
    task automatic stream(input int first, input int count, input int last_at);
        for (int i = 0; i < count; i++) begin
            send(DW'(first + i), (i + 1) == last_at);
        end
    endtask

    task automatic trace_off();
        tracing = 1'b0;
        check("elem_ready_low", elem_ready, 1'b0);
        @(posedge clk); #1;
        if (m_lane > 0) m_drop++;
        m_lane = 0;
        m_fcnt = 0;
        m_vec  = '0;
        check("enqueue_off", enqueue, 1'b0);
        check("dropped_count", dropped_count, 16'(m_drop));
    endtask

    task automatic trace_on();
        tracing = 1'b1;
        @(posedge clk); #1;
        check("elem_ready_high", elem_ready, 1'b1);
        check("enqueue_idle", enqueue, 1'b0);
    endtask

    // One config-mode cycle, with a valid element offered that must be
    // ignored because elem_ready is low.
    task automatic configure(input logic [7:0] id, input logic [7:0] data);
        configId   = id;
        configData = data;
        elem_valid = 1'b1;
        elem_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        elem_valid = 1'b0;
        configId   = 8'hFF;
        check("enqueue_cfg", enqueue, 1'b0);
        if (id == PID) m_flen = int'(data);
    endtask

    initial begin
        rst_n      = 1'b0;
        tracing    = 1'b0;
        configId   = 8'hFF;
        configData = 8'h00;
        elem_valid = 1'b0;
        elem_data  = '0;
        elem_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_enqueue", enqueue, 1'b0);
        check("rst_eof", eof_out, 1'b0);
        check("rst_vector", vector_out, '0);
        check("rst_dropped", dropped_count, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32 elements, frame_len 4: pulses every 8 accepts, eof on the 4th.
        // A config write offered while tracing must be ignored.
        trace_on();
        configId   = PID;
        configData = 8'd1;
        stream(1, 32, 0);
        configId   = 8'hFF;

        // Short vector closed by elem_last, then a full frame that shows the
        // frame count restarted at 0 (eof again on the 4th vector).
        send(32'hAAAA_0001, 1'b0);
        send(32'hBBBB_0002, 1'b0);
        send(32'hCCCC_0003, 1'b1);
        stream(33, 32, 0);

        // frame_len = 2; a mismatched configId leaves it alone.
        trace_off();
        configure(PID, 8'd2);
        configure(8'd5, 8'd7);
        trace_on();
        stream(101, 32, 0);

        // Partial vector dropped on the tracing fall, then a clean vector.
        stream(201, 5, 0);
        trace_off();
        trace_on();
        stream(301, 8, 0);

        // Unbounded frames: only elem_last ends one.
        trace_off();
        configure(PID, 8'd0);
        trace_on();
        stream(401, 24, 24);
        stream(501, 8, 8);
        @(posedge clk); #1;
        check("no_extra_pulse", enqueue, 1'b0);

        // Reset mid-vector at lane 6.
        stream(601, 6, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_enqueue", enqueue, 1'b0);
        check("async_rst_vector", vector_out, '0);
        check("async_rst_dropped", dropped_count, 16'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_lane = 0;
        m_fcnt = 0;
        m_flen = 4;
        m_drop = 0;
        m_vec  = '0;
        @(posedge clk); #1;
        check("post_rst_enqueue", enqueue, 1'b0);
        stream(701, 8, 0);
        stream(801, 24, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
